// File: rtl/next_pc_unit.sv
// Next-PC selection with a circular return-address stack.
// BL pushes PC+4, and RET pops the stack or falls back to RegTarget when it is empty.
module next_pc_unit #(
  parameter int unsigned     PC_W      = 64,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            CLK,
  input  logic            Reset_L,
  input  logic            Stall,
  input  logic [2:0]      BranchMode,
  input  logic            CondTrue,
  input  logic [PC_W-1:0] SignExtImm,
  input  logic [PC_W-1:0] RegTarget,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] NextPC,
  output logic [PC_W-1:0] LinkAddr,
  output logic            RasEmpty,
  output logic            RasFull,
  output logic            RasError
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  localparam logic [2:0] MODE_SEQ  = 3'd0;
  localparam logic [2:0] MODE_COND = 3'd1;
  localparam logic [2:0] MODE_B    = 3'd2;
  localparam logic [2:0] MODE_BL   = 3'd3;
  localparam logic [2:0] MODE_BR   = 3'd4;
  localparam logic [2:0] MODE_RET  = 3'd5;

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  // top_q is the next free slot; the newest entry sits just below it.
  logic [PTR_W-1:0] top_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic [PC_W-1:0]  pc_plus4;
  logic [PC_W-1:0]  br_target;
  logic [PC_W-1:0]  target;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;
  logic [PC_W-1:0]  ras_top;
  logic             push;
  logic             pop;
  logic             underflow;

  assign pc_plus4  = pc_q + PC_W'(4);
  assign br_target = pc_q + {SignExtImm[PC_W-3:0], 2'b00};
  assign top_inc   = (top_q == PTR_MAX) ? '0 : top_q + PTR_W'(1);
  assign top_dec   = (top_q == '0) ? PTR_MAX : top_q - PTR_W'(1);
  assign ras_top   = ras_q[top_dec];

  assign PC       = pc_q;
  assign LinkAddr = pc_plus4;
  assign RasEmpty = (count_q == '0);
  assign RasFull  = (count_q == CNT_FULL);
  assign RasError = err_q;

  always_comb begin
    target    = pc_plus4;
    push      = 1'b0;
    pop       = 1'b0;
    underflow = 1'b0;
    case (BranchMode)
      MODE_SEQ:  target = pc_plus4;
      MODE_COND: target = CondTrue ? br_target : pc_plus4;
      MODE_B:    target = br_target;
      MODE_BL: begin
        target = br_target;
        push   = 1'b1;
      end
      MODE_BR:   target = RegTarget;
      MODE_RET: begin
        if (!RasEmpty) begin
          target = ras_top;
          pop    = 1'b1;
        end else begin
          target    = RegTarget;
          underflow = 1'b1;
        end
      end
      default:   target = pc_plus4;
    endcase
    NextPC = {target[PC_W-1:2], 2'b00};
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      pc_q    <= RESET_PC;
      top_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (!Stall) begin
      pc_q <= NextPC;
      if (push) begin
        top_q <= top_inc;
        if (RasFull) begin
          err_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end else if (pop) begin
        top_q   <= top_dec;
        count_q <= count_q - CNT_W'(1);
      end else if (underflow) begin
        err_q <= 1'b1;
      end
    end
  end

  // Entry storage is not reset; only the count and pointer determine validity.
  always_ff @(posedge CLK) begin
    if (!Stall && push) begin
      ras_q[top_q] <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit using the default parameters.
module tb_next_pc_unit;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        Stall;
  logic [2:0]  BranchMode;
  logic        CondTrue;
  logic [63:0] SignExtImm;
  logic [63:0] RegTarget;
  logic [63:0] PC;
  logic [63:0] NextPC;
  logic [63:0] LinkAddr;
  logic        RasEmpty;
  logic        RasFull;
  logic        RasError;

  int vectors = 0;
  int miscompares = 0;

  next_pc_unit dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .Stall      (Stall),
    .BranchMode (BranchMode),
    .CondTrue   (CondTrue),
    .SignExtImm (SignExtImm),
    .RegTarget  (RegTarget),
    .PC         (PC),
    .NextPC     (NextPC),
    .LinkAddr   (LinkAddr),
    .RasEmpty   (RasEmpty),
    .RasFull    (RasFull),
    .RasError   (RasError)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] mode, input logic [63:0] imm, input logic [63:0] rt);
    BranchMode = mode;
    SignExtImm = imm;
    RegTarget  = rt;
  endtask

  // Advance one edge and sample 1 ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset_L = 1'b0;
    Stall = 1'b0;
    CondTrue = 1'b0;
    drive(3'd0, 64'h0, 64'h0);
    #2;
    chk("reset_pc", PC, 64'h0);
    chk("reset_empty", {63'b0, RasEmpty}, 64'h1);
    chk("reset_full", {63'b0, RasFull}, 64'h0);
    chk("reset_err", {63'b0, RasError}, 64'h0);
    chk("reset_nextpc", NextPC, 64'h4);
    chk("reset_link", LinkAddr, 64'h4);
    #10 Reset_L = 1'b1;

    // Sequential fetch
    step(); chk("seq1", PC, 64'h4);
    step(); chk("seq2", PC, 64'h8);
    step(); chk("seq3", PC, 64'hC);

    // Conditional branch around PC=0x100 with offset -2 words
    drive(3'd4, 64'h0, 64'h100);
    step(); chk("br_0x100", PC, 64'h100);
    drive(3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
    CondTrue = 1'b1; #1; chk("cond_taken", NextPC, 64'hF8);
    CondTrue = 1'b0; #1; chk("cond_not_taken", NextPC, 64'h104);
    drive(3'd4, 64'h0, 64'h203); #1; chk("br_align", NextPC, 64'h200);

    // BL then RET
    drive(3'd4, 64'h0, 64'h20);
    step(); chk("br_0x20", PC, 64'h20);
    drive(3'd3, 64'h10, 64'h0); #1; chk("bl_next", NextPC, 64'h60);
    step();
    chk("bl_pc", PC, 64'h60);
    chk("bl_notempty", {63'b0, RasEmpty}, 64'h0);
    drive(3'd5, 64'h0, 64'hDEAD0); #1; chk("ret_top", NextPC, 64'h24);
    step();
    chk("ret_pc", PC, 64'h24);
    chk("ret_empty", {63'b0, RasEmpty}, 64'h1);
    chk("ret_noerr", {63'b0, RasError}, 64'h0);

    // Branch to self
    drive(3'd2, 64'h0, 64'h0);
    step(); chk("self1", PC, 64'h24);
    step(); chk("self2", PC, 64'h24);

    // BL held under stall for three edges
    drive(3'd3, 64'h4, 64'h0);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", PC, 64'h24);
      chk("stall_empty", {63'b0, RasEmpty}, 64'h1);
    end
    Stall = 1'b0;
    step();
    chk("unstall_pc", PC, 64'h34);
    chk("unstall_push", {63'b0, RasEmpty}, 64'h0);
    drive(3'd5, 64'h0, 64'h0); #1; chk("unstall_top", NextPC, 64'h28);
    step(); chk("unstall_ret", PC, 64'h28);

    // Five nested BLs into a four-entry stack
    drive(3'd3, 64'h40, 64'h0);
    step(); chk("nest1", PC, 64'h128);
    step(); chk("nest2", PC, 64'h228);
    step(); chk("nest3", PC, 64'h328);
    step(); chk("nest4", PC, 64'h428);
    chk("nest4_full", {63'b0, RasFull}, 64'h1);
    chk("nest4_noerr", {63'b0, RasError}, 64'h0);
    step(); chk("nest5", PC, 64'h528);
    chk("nest5_full", {63'b0, RasFull}, 64'h1);
    chk("nest5_err", {63'b0, RasError}, 64'h1);
    drive(3'd5, 64'h0, 64'h9000);
    step(); chk("pop1", PC, 64'h42C);
    step(); chk("pop2", PC, 64'h32C);
    step(); chk("pop3", PC, 64'h22C);
    step(); chk("pop4", PC, 64'h12C);
    chk("pop4_empty", {63'b0, RasEmpty}, 64'h1);
    step(); chk("pop5_regtarget", PC, 64'h9000);
    chk("pop5_err", {63'b0, RasError}, 64'h1);

    // Async reset between edges with two stacked entries
    drive(3'd3, 64'h1, 64'h0);
    step(); step();
    chk("pre_reset_pc", PC, 64'h9008);
    chk("pre_reset_err", {63'b0, RasError}, 64'h1);
    #2 Reset_L = 1'b0;
    #1;
    chk("async_pc", PC, 64'h0);
    chk("async_empty", {63'b0, RasEmpty}, 64'h1);
    chk("async_err", {63'b0, RasError}, 64'h0);
    #1 Reset_L = 1'b1;

    // Underflow right after reset
    drive(3'd5, 64'h0, 64'h50); #1; chk("uflow_next", NextPC, 64'h50);
    step();
    chk("uflow_pc", PC, 64'h50);
    chk("uflow_err", {63'b0, RasError}, 64'h1);
    chk("uflow_empty", {63'b0, RasEmpty}, 64'h1);

    // Reserved mode behaves as sequential
    drive(3'd7, 64'h10, 64'h1000);
    step(); chk("reserved", PC, 64'h54);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 Parameter PC_W, default 64, width of PC, offset, register target and link values.
REQ-002 Parameter RAS_DEPTH, default 4, number of return-address-stack entries; legal range 2..16.
REQ-003 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 Reset_L  input  1  asynchronous, active-low reset.
REQ-006 Stall  input  1  when 1, holds PC and return stack.
REQ-007 BranchMode  input  3  0 SEQ, 1 COND, 2 B, 3 BL, 4 BR, 5 RET, 6..7 reserved.
REQ-008 CondTrue  input  1  branch condition for COND mode (ALU zero / flag result).
REQ-009 SignExtImm  input  PC_W  sign-extended word offset; not yet shifted.
REQ-010 RegTarget  input  PC_W  register-sourced target for BR, and for RET when the stack is empty.
REQ-011 PC  output  PC_W  current program counter (registered).
REQ-012 NextPC  output  PC_W  combinational value PC will take at the next un-stalled edge.
REQ-013 LinkAddr  output  PC_W  PC+4, valid every cycle; the value written to X30 on BL.
REQ-014 RasEmpty  output  1  stack holds 0 entries.
REQ-015 RasFull  output  1  stack holds RAS_DEPTH entries.
REQ-016 RasError  output  1  sticky flag: overflow or underflow has occurred since reset.

Function
REQ-017 Sequential target SHALL be PC+4; branch target SHALL be PC + (SignExtImm << 2); all sums are modulo 2^PC_W.
REQ-018 NextPC SHALL select by mode as follows:
- SEQ and reserved: PC+4.
- COND: branch target if CondTrue=1, else PC+4.
- B and BL: branch target.
- BR: RegTarget.
- RET: stack top if not empty, else RegTarget.
REQ-019 Bits [1:0] of NextPC SHALL be forced to 0 in every mode.
REQ-020 On each rising edge with Stall=0, PC SHALL load NextPC; with Stall=1, PC, the stack, its count and RasError SHALL hold.
REQ-021 BL with Stall=0 SHALL push LinkAddr onto the stack at that edge.
REQ-022 RET with Stall=0 and stack not empty SHALL pop the top entry at that edge.
REQ-023 The stack SHALL be circular with a top pointer and a count from 0 to RAS_DEPTH.
REQ-024 A push when full SHALL overwrite the oldest entry, keep count at RAS_DEPTH and set RasError.
REQ-025 A RET when empty SHALL leave the count at 0 and set RasError.
REQ-026 Modes other than BL and RET SHALL not modify the stack.
REQ-027 Branch-to-self (offset 0) SHALL hold the PC value every cycle.
REQ-028 No mode SHALL perform a push and a pop in the same edge.
REQ-029 RasEmpty and RasFull SHALL be decoded combinationally from the registered count.

Reset
REQ-030 While Reset_L=0, the block SHALL force, independent of CLK:
- PC = RESET_PC;
- stack count = 0 and top pointer = 0;
- RasError = 0, RasEmpty = 1, RasFull = 0.
REQ-031 Stack entry contents need not be reset.
REQ-032 Reset asserted mid-stall or mid-sequence SHALL discard all pending state.
REQ-033 The first edge after Reset_L rises SHALL apply normal REQ-018 behaviour.

Verification
REQ-034 Reset, then 3 SEQ cycles -> PC = 0x0, 0x4, 0x8, 0xC.
REQ-035 COND with PC=0x100 and SignExtImm=-2:
- CondTrue=1 -> NextPC=0xF8;
- CondTrue=0 -> NextPC=0x104.
REQ-036 BL at PC=0x20 with SignExtImm=0x10 -> PC=0x60, stack top=0x24. Then RET -> PC=0x24, RasEmpty=1.
REQ-037 RAS_DEPTH=4, 5 nested BLs then 5 RETs:
- first 4 RETs return the 4 newest links;
- 5th RET takes RegTarget;
- RasError=1.
REQ-038 Stall=1 held for 3 cycles during BL -> PC and count unchanged; the push occurs only on the first un-stalled edge.
REQ-039 Reset_L pulsed low asynchronously between edges with the stack holding 2 entries:
- PC = RESET_PC immediately;
- RasEmpty=1, RasError=0.
